rua_boot_loader: RTL and testbench

- Sits upstream of the rua core and its byte RAM.
- Receives a framed program image over a byte stream (valid/ready) and writes it into the RAM byte by byte, holding the core in reset throughout.
- After a correct checksum it releases core reset; it never releases the core on a bad or oversized image.
- Replaces the simulation-only preload of RAM contents, so the same flow works on hardware.

---
 rtl/rua_boot_pkg.sv | 16 +
 rtl/rua_boot_loader.sv | 138 +++++++++++++
 tb/tb_rua_boot_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rua_boot_pkg.sv
// Shared encodings for the rua boot loader.
package rua_boot_pkg;

  // Loader FSM states; encoding is fixed so it can be observed from outside.
  typedef enum logic [2:0] {
    StHdr  = 3'd0,
    StData = 3'd1,
    StSum  = 3'd2,
    StRun  = 3'd3,
    StErr  = 3'd4
  } state_e;

  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned SUM_W     = 8;

endpackage

// File: rtl/rua_boot_loader.sv
// Boot loader: receives a framed image (LEN, payload, checksum) over a valid/ready byte stream,
// writes the payload into byte RAM and releases the core only after a good checksum.
module rua_boot_loader
  import rua_boot_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 5300,
  parameter int unsigned ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam int unsigned HdrCntW = $clog2(HDR_BYTES);
  localparam logic [HdrCntW-1:0] LastHdr = HdrCntW'(HDR_BYTES - 1);

  state_e             state_q, state_d;
  logic [31:0]        hdr_q, hdr_d;
  logic [HdrCntW-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [31:0]        len_q, len_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [7:0]         ram_wdata_q, ram_wdata_d;

  // Header arrives little-endian: new bytes enter at the top and shift down.
  logic [31:0] len_in;
  assign len_in = {in_data, hdr_q[31:8]};

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHdr;
      hdr_q       <= '0;
      hdr_cnt_q   <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdr_cnt_q   <= hdr_cnt_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    hdr_cnt_d   = hdr_cnt_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    in_ready    = 1'b0;
    core_rst    = 1'b1;
    done        = 1'b0;
    error       = 1'b0;

    unique case (state_q)
      StHdr: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hdr_d     = len_in;
          hdr_cnt_d = hdr_cnt_q + 1'b1;
          if (hdr_cnt_q == LastHdr) begin
            hdr_cnt_d = '0;
            len_d     = len_in;
            cnt_d     = '0;
            sum_d     = '0;
            // Full 32-bit compare so oversized lengths can never wrap into range.
            if (len_in > MEM_BYTES) begin
              state_d = StErr;
            end else if (len_in == 32'd0) begin
              state_d = StSum;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = cnt_q[ADDR_W-1:0];
          ram_wdata_d = in_data;
          sum_d       = sum_q + in_data;
          cnt_d       = cnt_q + 32'd1;
          if (cnt_q == len_q - 32'd1) begin
            state_d = StSum;
          end
        end
      end
      StSum: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (in_data == sum_q) ? StRun : StErr;
        end
      end
      StRun: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      StErr: begin
        error = 1'b1;
      end
      default: begin
        state_d = StErr;
      end
    endcase
  end

endmodule

// File: tb/tb_rua_boot_loader.sv
// Directed self-checking bench for rua_boot_loader.
module tb_rua_boot_loader;

  localparam int unsigned MEM_BYTES = 5300;
  localparam int unsigned ADDR_W    = 13;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  logic [3:0] status;
  assign status = {in_ready, core_rst, done, error};

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [7:0] mem [MEM_BYTES];

  rua_boot_loader #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // RAM model fed by the loader's write port.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (status !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_status: got %b want 1100", status);
    end
    n_checks++;
    if ({ram_we, ram_addr, ram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_ram: we=%b addr=%0d data=%h want all zero", ram_we, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_basic();
    logic [7:0] p [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int w0;
    do_reset();
    w0 = wr_count;
    send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    n_checks++;
    if ({ram_we, status} !== 5'b0_1100) begin
      n_fail++;
      $display("FAIL basic_hdr: got we,status=%b want 0_1100", {ram_we, status});
    end
    for (int i = 0; i < 4; i++) begin
      send(p[i]);
      n_checks++;
      if ({ram_we, ram_addr, ram_wdata} !== {1'b1, ADDR_W'(i), p[i]}) begin
        n_fail++;
        $display("FAIL basic_wr%0d: got we=%b addr=%0d data=%h want 1 %0d %h",
                 i, ram_we, ram_addr, ram_wdata, i, p[i]);
      end
    end
    n_checks++;
    if (status !== 4'b1100) begin
      n_fail++;
      $display("FAIL basic_pre_sum: got %b want 1100", status);
    end
    send(8'h0E);
    n_checks++;
    if ({ram_we, status} !== 5'b0_0010) begin
      n_fail++;
      $display("FAIL basic_done: got we,status=%b want 0_0010", {ram_we, status});
    end
    idle(2);
    n_checks++;
    if ({status, ram_addr, ram_wdata} !== {4'b0010, ADDR_W'(3), 8'hDD}) begin
      n_fail++;
      $display("FAIL basic_hold: got %b addr=%0d data=%h want 0010 3 dd", status, ram_addr, ram_wdata);
    end
    n_checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hAABBCCDD || wr_count - w0 !== 4) begin
      n_fail++;
      $display("FAIL basic_mem: got %h%h%h%h writes=%0d want aabbccdd 4",
               mem[0], mem[1], mem[2], mem[3], wr_count - w0);
    end
  endtask

  task automatic test_bad_sum();
    logic [7:0] f [9] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0F};
    do_reset();
    for (int i = 0; i < 9; i++) send(f[i]);
    n_checks++;
    if (status !== 4'b0101) begin
      n_fail++;
      $display("FAIL bad_sum: got %b want 0101", status);
    end
    send(8'h00);
    idle(3);
    n_checks++;
    if ({ram_we, status} !== 5'b0_0101) begin
      n_fail++;
      $display("FAIL bad_sum_sticky: got %b want 0_0101", {ram_we, status});
    end
  endtask

  task automatic test_len_zero();
    int w0;
    do_reset();
    w0 = wr_count;
    for (int i = 0; i < 5; i++) send(8'h00);
    idle(1);
    n_checks++;
    if (status !== 4'b0010 || wr_count !== w0) begin
      n_fail++;
      $display("FAIL len_zero: got %b writes=%0d want 0010 0", status, wr_count - w0);
    end
  endtask

  task automatic test_len_over();
    logic [7:0] h [2][4] = '{'{8'hB5, 8'h14, 8'h00, 8'h00}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    int w0;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      w0 = wr_count;
      for (int i = 0; i < 4; i++) send(h[k][i]);
      n_checks++;
      if (status !== 4'b0101) begin
        n_fail++;
        $display("FAIL len_over%0d: got %b want 0101", k, status);
      end
      send(8'h12);
      idle(2);
      n_checks++;
      if (wr_count !== w0 || status !== 4'b0101) begin
        n_fail++;
        $display("FAIL len_over%0d_nowr: writes=%0d status=%b want 0 0101", k, wr_count - w0, status);
      end
    end
  endtask

  task automatic test_len_max();
    logic [7:0] b;
    logic [7:0] sum_m = 8'h00;
    int w0;
    do_reset();
    w0 = wr_count;
    send(8'hB4); send(8'h14); send(8'h00); send(8'h00);
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      b = 8'(i * 7 + 3);
      sum_m += b;
      send(b);
    end
    n_checks++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, ADDR_W'(5299), 8'(5299 * 7 + 3)}) begin
      n_fail++;
      $display("FAIL len_max_last: got we=%b addr=%0d data=%h want 1 5299 %h",
               ram_we, ram_addr, ram_wdata, 8'(5299 * 7 + 3));
    end
    send(sum_m);
    idle(1);
    n_checks++;
    if (status !== 4'b0010 || wr_count - w0 !== int'(MEM_BYTES) || mem[5299] !== 8'(5299 * 7 + 3)) begin
      n_fail++;
      $display("FAIL len_max_done: status=%b writes=%0d mem5299=%h want 0010 5300 %h",
               status, wr_count - w0, mem[5299], 8'(5299 * 7 + 3));
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] f [9] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
    int gap;
    int w0;
    do_reset();
    w0 = wr_count;
    for (int i = 0; i < 9; i++) begin
      gap = (i == 8) ? 3 : int'($urandom_range(0, 3));
      if (gap > 0) begin
        idle(gap);
        n_checks++;
        if ({ram_we, status} !== 5'b0_1100) begin
          n_fail++;
          $display("FAIL bp_gap%0d: got we,status=%b want 0_1100", i, {ram_we, status});
        end
      end
      send(f[i]);
      if (i >= 4 && i < 8) begin
        n_checks++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, ADDR_W'(i - 4), f[i]}) begin
          n_fail++;
          $display("FAIL bp_wr%0d: got we=%b addr=%0d data=%h want 1 %0d %h",
                   i - 4, ram_we, ram_addr, ram_wdata, i - 4, f[i]);
        end
      end
    end
    n_checks++;
    if (status !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_done: got %b want 0010", status);
    end
    idle(1);
    n_checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hAABBCCDD || wr_count - w0 !== 4) begin
      n_fail++;
      $display("FAIL bp_mem: got %h%h%h%h writes=%0d want aabbccdd 4",
               mem[0], mem[1], mem[2], mem[3], wr_count - w0);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] f [9] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    int w0;
    do_reset();
    w0 = wr_count;
    send(8'h04); send(8'h00); send(8'h00); send(8'h00); send(8'h11); send(8'h22);
    // Reset coincides with a handshake; that byte must be dropped.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({status, ram_we, ram_addr, ram_wdata} !== {4'b1100, 1'b0, ADDR_W'(0), 8'h00}) begin
      n_fail++;
      $display("FAIL mid_rst: got status=%b we=%b addr=%0d data=%h want 1100 0 0 00",
               status, ram_we, ram_addr, ram_wdata);
    end
    n_checks++;
    if (wr_count - w0 !== 2) begin
      n_fail++;
      $display("FAIL mid_rst_writes: got %0d want 2", wr_count - w0);
    end
    for (int i = 0; i < 9; i++) send(f[i]);
    n_checks++;
    if (status !== 4'b0010 || {mem[0], mem[1], mem[2], mem[3]} !== 32'h01020304) begin
      n_fail++;
      $display("FAIL mid_rst_reload: status=%b mem=%h%h%h%h want 0010 01020304",
               status, mem[0], mem[1], mem[2], mem[3]);
    end
    do_reset();
    n_checks++;
    if (status !== 4'b1100) begin
      n_fail++;
      $display("FAIL run_rst: got %b want 1100", status);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_sum();
    test_len_zero();
    test_len_over();
    test_len_max();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
